// File: rtl/range_clamp_fifo_pkg.sv
// Shared constants for the range-clamped 4-bit sample path.
// The downstream capture stage uses the same width and legal maximum.
package range_clamp_fifo_pkg;

    localparam int unsigned SAMPLE_W = 4;
    localparam int unsigned MAX_CODE = 11;
    localparam int unsigned CNT_W    = 8;

endpackage

// File: rtl/range_clamp_sat.sv
// Combinational saturator: codes above MAX_VAL become MAX_VAL, with a clamp flag.
module range_clamp_sat
    import range_clamp_fifo_pkg::*;
#(
    parameter int unsigned DW      = SAMPLE_W,
    parameter int unsigned MAX_VAL = MAX_CODE
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          clamp
);

    localparam logic [DW-1:0] MaxQ = DW'(MAX_VAL);

    always_comb begin
        clamp = (din > MaxQ);
        dout  = clamp ? MaxQ : din;
    end

endmodule

// File: rtl/range_clamp_fifo.sv
// FWFT FIFO that saturates out-of-range samples at its write port.
// Define RANGE_VIOL_CNT_EN to add the saturating viol_cnt clamp-event counter.
module range_clamp_fifo
    import range_clamp_fifo_pkg::*;
#(
    parameter int unsigned DW      = SAMPLE_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_VAL = MAX_CODE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          clamped
`ifdef RANGE_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          clamped_q;
    logic [DW-1:0] sat_val;
    logic          sat_clamp;
    logic          push, pop;

    range_clamp_sat #(
        .DW      (DW),
        .MAX_VAL (MAX_VAL)
    ) u_sat (
        .din   (din),
        .dout  (sat_val),
        .clamp (sat_clamp)
    );

    // din_ready depends only on registered count, never on dout_ready.
    assign din_ready  = (count_q != FullCnt);
    assign dout_valid = (count_q != '0);
    assign dout       = mem_q[rd_ptr_q];
    assign clamped    = clamped_q;
    assign push       = din_valid && din_ready;
    assign pop        = dout_valid && dout_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clamped_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= sat_val;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            clamped_q <= push && sat_clamp;
        end
    end

`ifdef RANGE_VIOL_CNT_EN
    logic [CNT_W-1:0] viol_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_q <= '0;
        end else if (push && sat_clamp && (viol_cnt_q != '1)) begin
            viol_cnt_q <= viol_cnt_q + 1'b1;
        end
    end

    assign viol_cnt = viol_cnt_q;
`endif

endmodule

// File: tb/tb_range_clamp_fifo.sv
// Scoreboard bench for range_clamp_fifo; driver queues expected outputs, monitor pops them.
// Covers the viol_cnt counter when RANGE_VIOL_CNT_EN is defined.
module tb_range_clamp_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       clamped;
`ifdef RANGE_VIOL_CNT_EN
    logic [7:0] viol_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    range_clamp_fifo #(
        .DW      (4),
        .DEPTH   (4),
        .MAX_VAL (11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .clamped    (clamped)
`ifdef RANGE_VIOL_CNT_EN
        ,
        .viol_cnt   (viol_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake on the output side consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                check("dout", int'(dout), exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic [3:0] v, input logic vld, input logic rdy);
        logic acc;
        din = v;
        din_valid = vld;
        dout_ready = rdy;
        @(negedge clk);
        acc = vld && din_ready;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back((v > 4'd11) ? 11 : int'(v));
        check("clamped", int'(clamped), int'(acc && (v > 4'd11)));
        if (acc && (v > 4'd11) && (vcnt < 255)) vcnt++;
`ifdef RANGE_VIOL_CNT_EN
        check("viol_cnt", int'(viol_cnt), vcnt);
`endif
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [5];
        seq[0] = 4'd3; seq[1] = 4'd7; seq[2] = 4'd11; seq[3] = 4'd12; seq[4] = 4'd15;

        repeat (2) @(posedge clk);
        #1;
        check("rst_din_ready", int'(din_ready), 1);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_clamped", int'(clamped), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // In-range then out-of-range samples, consumer always ready.
        for (int i = 0; i < 3; i++) cycle(seq[i], 1'b1, 1'b1);
        drain(2);
        for (int i = 3; i < 5; i++) cycle(seq[i], 1'b1, 1'b1);
        drain(2);
`ifdef RANGE_VIOL_CNT_EN
        check("viol_cnt_two", int'(viol_cnt), 2);
`endif

        // Fill to full with the consumer stalled.
        for (int i = 0; i < 5; i++) begin
            cycle(4'(i + 1), 1'b1, 1'b0);
            check("fill_din_ready", int'(din_ready), (i < 3) ? 1 : 0);
        end
        cycle(4'd0, 1'b0, 1'b1);
        check("after_pop_din_ready", int'(din_ready), 1);
        check("after_pop_dout", int'(dout), 2);
        drain(4);
        check("drained_valid", int'(dout_valid), 0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 20; i++) begin
            cycle(4'(i % 12), 1'b1, 1'b1);
            check("stream_din_ready", int'(din_ready), 1);
            check("stream_occupancy", exp_q.size(), 1);
        end
        drain(1);

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) cycle(4'(i + 4), 1'b1, 1'b0);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout_valid", int'(dout_valid), 0);
        check("arst_din_ready", int'(din_ready), 1);
        check("arst_dout", int'(dout), 0);
`ifdef RANGE_VIOL_CNT_EN
        check("arst_viol_cnt", int'(viol_cnt), 0);
`endif
        exp_q.delete();
        vcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(4'd9, 1'b1, 1'b0);
        check("post_rst_head", int'(dout), 9);
        drain(2);

        // Counter saturation.
        for (int i = 0; i < 260; i++) cycle(4'd14, 1'b1, 1'b1);
        drain(2);
`ifdef RANGE_VIOL_CNT_EN
        check("viol_cnt_sat", int'(viol_cnt), 255);
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
